// File: rtl/row_clear_ctrl.sv
// row_clear_ctrl: line-clear sequencer for the playfield pixel map.
// A start pulse launches a bottom-to-top scan. Each full row is removed by
// one load of the map register with the rows above it dropped by one. The
// scan then revisits the same row index to catch the row that fell into it.
// The number of rows removed is reported for scoring.
//
// Handshake: start is a single-cycle request. It is accepted only when busy=0
// and is ignored while busy=1. done pulses for one cycle when the pass ends,
// and lines_cleared is stable from that pulse until the next accepted start.
// While busy=1 this block owns the map load path (load_reg/board_out).
module row_clear_ctrl #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int CW   = 4
) (
  input  logic                                Clk,
  input  logic                                Reset,
  input  logic                                start,
  input  logic [ROWS-1:0][COLS-1:0][CW-1:0]   board_in,
  output logic [ROWS-1:0][COLS-1:0][CW-1:0]   board_out,
  output logic                                load_reg,
  output logic                                busy,
  output logic                                done,
  output logic [4:0]                          lines_cleared,
  output logic [1:0]                          dbgState
);

  localparam int RW = $clog2(ROWS);
  localparam logic [RW-1:0] ROW_BOTTOM = RW'(ROWS - 1);
  localparam logic [4:0]    LINES_MAX  = 5'(ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, stateNext;
  logic [RW-1:0] row, rowNext;
  logic [4:0]    linesNext;
  logic          rowFull;

  // State, row pointer and line counter registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= IDLE;
      row           <= ROW_BOTTOM;
      lines_cleared <= '0;
    end else begin
      state         <= stateNext;
      row           <= rowNext;
      lines_cleared <= linesNext;
    end
  end

  // A row is full when every cell in it is nonzero
  always_comb begin
    rowFull = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (board_in[row][c] == '0) rowFull = 1'b0;
    end
  end

  // Next-state, pointer and counter update plus the status outputs
  always_comb begin
    stateNext = state;
    rowNext   = row;
    linesNext = lines_cleared;
    load_reg  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          stateNext = SCAN;
          rowNext   = ROW_BOTTOM;
          linesNext = '0;
        end
      end
      SCAN: begin
        if (rowFull) begin
          stateNext = SHIFT;
        end else if (row == '0) begin
          stateNext = DONE;
        end else begin
          rowNext = row - 1'b1;
        end
      end
      SHIFT: begin
        // The map loads on this edge, so the rescan of the same row sees
        // the collapsed contents.
        load_reg  = 1'b1;
        stateNext = SCAN;
        if (lines_cleared != LINES_MAX) linesNext = lines_cleared + 1'b1;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Collapsed board: drop everything above the current row by one, zero-fill the top
  always_comb begin
    board_out = board_in;
    for (int r = 0; r < ROWS; r++) begin
      if (r == 0) begin
        board_out[r] = '0;
      end else if (r <= int'(row)) begin
        board_out[r] = board_in[r-1];
      end
    end
  end

  // Expose the FSM state for observation
  always_comb begin
    dbgState = state;
  end

endmodule

// File: tb/tb_row_clear_ctrl.sv
// tb_row_clear_ctrl: directed table of boards run through full clear passes,
// with a bench-side map register closing the load loop, plus hand-written
// sequences for start re-pulse while busy and reset during a shift.
module tb_row_clear_ctrl;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int CW   = 4;
  localparam int NVEC = 7;

  typedef logic [COLS-1:0][CW-1:0] row_t;
  typedef logic [ROWS-1:0][COLS-1:0][CW-1:0] board_t;

  typedef struct {
    string  name;
    board_t init;
    board_t expB;
    int     expLines;
  } vec_t;

  logic   Clk = 1'b0;
  logic   Reset;
  logic   start;
  board_t board_in;
  board_t board_out;
  logic   load_reg;
  logic   busy;
  logic   done;
  logic [4:0] lines_cleared;
  logic [1:0] dbgState;

  board_t mapReg;
  board_t tbBoard;
  logic   tbLoad;

  int nCompared = 0;
  int nMismatch = 0;

  vec_t vecs[NVEC];

  row_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .CW(CW)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .start        (start),
    .board_in     (board_in),
    .board_out    (board_out),
    .load_reg     (load_reg),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared),
    .dbgState     (dbgState)
  );

  // Clock
  always #5 Clk = ~Clk;

  // Bench model of the map register: the DUT load wins, else the bench preload
  always @(posedge Clk) begin
    if (load_reg) mapReg <= board_out;
    else if (tbLoad) mapReg <= tbBoard;
  end

  assign board_in = mapReg;

  // Scalar comparison
  task automatic chk(input string nm, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatch++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Board comparison, reporting the first differing row
  task automatic chk_board(input string nm, input board_t act, input board_t exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      for (int r = 0; r < ROWS; r++) begin
        if (act[r] !== exp[r]) begin
          $display("FAIL %s: row %0d got %h expected %h", nm, r, act[r], exp[r]);
          break;
        end
      end
    end
  endtask

  function automatic row_t mk_full(input int s);
    row_t rw;
    for (int c = 0; c < COLS; c++) rw[c] = CW'(1 + ((s + c) % 15));
    return rw;
  endfunction

  function automatic row_t mk_part(input int s, input int hole);
    row_t rw;
    rw = mk_full(s);
    rw[hole] = '0;
    return rw;
  endfunction

  function automatic row_t mk_sparse();
    row_t rw;
    for (int c = 0; c < COLS; c++)
      rw[c] = ($urandom_range(0, 2) == 0) ? CW'($urandom_range(1, 15)) : '0;
    rw[$urandom_range(0, COLS - 1)] = '0;
    return rw;
  endfunction

  // Reference: keep non-full rows in bottom-up order, pack them to the bottom
  function automatic board_t compact(input board_t b);
    board_t res;
    int     dst;
    logic   full;
    res = '0;
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (b[r][c] == '0) full = 1'b0;
      if (!full) begin
        res[dst] = b[r];
        dst--;
      end
    end
    return res;
  endfunction

  task automatic preload(input board_t b);
    @(negedge Clk);
    tbBoard = b;
    tbLoad  = 1'b1;
    @(negedge Clk);
    tbLoad  = 1'b0;
  endtask

  // One full pass; repulseCyc>0 drives an extra start during that busy cycle
  task automatic run_pass(input string nm, input board_t init, input board_t expB,
                          input int expLines, input int repulseCyc);
    int cyc, doneCyc, loads;
    preload(init);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    cyc = 1; doneCyc = -1; loads = 0;
    chk({nm, "_busy_c1"}, int'(busy), 1);
    while (cyc <= 100 && doneCyc < 0) begin
      if (load_reg) loads++;
      if (done) doneCyc = cyc;
      if (doneCyc < 0) begin
        @(negedge Clk);
        cyc++;
        start = (cyc == repulseCyc);
      end
    end
    start = 1'b0;
    chk({nm, "_done_cycle"}, doneCyc, 21 + 2 * expLines);
    chk({nm, "_loads"}, loads, expLines);
    @(negedge Clk);
    chk({nm, "_done_1cyc"}, int'(done), 0);
    chk({nm, "_busy_end"}, int'(busy), 0);
    chk({nm, "_lines"}, int'(lines_cleared), expLines);
    chk_board({nm, "_board"}, mapReg, expB);
  endtask

  initial begin
    board_t b;
    row_t   pat;
    int     idleBusy;

    Reset  = 1'b1;
    start  = 1'b0;
    tbLoad = 1'b0;
    tbBoard = '0;

    // Vector table
    vecs[0].name = "empty";
    vecs[0].init = '0;
    vecs[0].expLines = 0;

    pat = mk_part(3, 4);
    b = '0; b[19] = mk_full(1); b[18] = pat;
    vecs[1].name = "row19"; vecs[1].init = b; vecs[1].expLines = 1;

    b = '0;
    for (int r = 0; r < 16; r++) b[r] = mk_sparse();
    for (int r = 16; r < 20; r++) b[r] = mk_full(r);
    vecs[2].name = "tetris"; vecs[2].init = b; vecs[2].expLines = 4;

    b = '0; b[19] = mk_full(2); b[18] = mk_part(5, 0); b[17] = mk_full(7);
    b[16] = mk_part(9, 9);
    vecs[3].name = "gap"; vecs[3].init = b; vecs[3].expLines = 2;

    b = '0; b[0] = mk_full(4); b[10] = mk_part(6, 3); b[19] = mk_part(8, 7);
    vecs[4].name = "row0"; vecs[4].init = b; vecs[4].expLines = 1;

    for (int r = 0; r < ROWS; r++) b[r] = mk_full(r);
    vecs[5].name = "allfull"; vecs[5].init = b; vecs[5].expLines = 20;

    for (int r = 0; r < ROWS; r++) b[r] = mk_sparse();
    b[3] = mk_full(11); b[10] = mk_full(12); b[11] = mk_full(13);
    vecs[6].name = "mixed"; vecs[6].init = b; vecs[6].expLines = 3;

    for (int i = 0; i < NVEC; i++) vecs[i].expB = compact(vecs[i].init);

    // Reset state
    repeat (3) @(negedge Clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_load", int'(load_reg), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_lines", int'(lines_cleared), 0);
    Reset = 1'b0;

    // Table-driven passes
    for (int i = 0; i < NVEC; i++)
      run_pass(vecs[i].name, vecs[i].init, vecs[i].expB, vecs[i].expLines, 0);

    // Hand checks on the single-line and tetris results
    preload(vecs[1].init);
    run_pass("row19_again", vecs[1].init, vecs[1].expB, 1, 0);
    chk_board("row19_is_P", {mapReg[19], mapReg[0]}, {pat, row_t'('0)});
    run_pass("tetris_again", vecs[2].init, vecs[2].expB, 4, 0);
    chk_board("tetris_drop", {mapReg[19:16], mapReg[3:0]},
              {vecs[2].init[15:12], 160'b0});

    // start re-pulsed during the shift and mid-scan: no second pass
    run_pass("repulse_shift", vecs[1].init, vecs[1].expB, 1, 2);
    run_pass("repulse_scan", vecs[3].init, vecs[3].expB, 2, 9);
    idleBusy = 0;
    repeat (4) begin
      @(negedge Clk);
      if (busy) idleBusy++;
    end
    chk("repulse_no_rerun", idleBusy, 0);

    // Reset asserted during SHIFT
    preload(vecs[1].init);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    chk("rs_c1_load", int'(load_reg), 0);
    @(negedge Clk);
    chk("rs_c2_load", int'(load_reg), 1);
    Reset = 1'b1;
    #1;
    chk("rs_busy", int'(busy), 0);
    chk("rs_load", int'(load_reg), 0);
    chk("rs_lines", int'(lines_cleared), 0);
    @(negedge Clk);
    Reset = 1'b0;
    chk_board("rs_map_kept", mapReg, vecs[1].init);
    run_pass("after_reset", vecs[4].init, vecs[4].expB, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
